round_sequencer: RTL and testbench

- Round-level controller for the whack-a-mole game.
- Requests a new unique target from the selector and publishes it to the display.
- Runs the per-round response window and judges the user's press as hit, wrong-number miss or timeout miss.
- Keeps score, shortens the response window after each hit, enforces an inter-round delay, and ends the game after a set number of misses.

---
 rtl/round_sequencer.sv | 137 +++++++++++++
 tb/tb_round_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Whack-a-mole round controller: requests a target, times the response window, scores hits and misses.
// sel_req is a registered-state decode one cycle after start/DELAY; selector and user strobes are only honoured in their own states.
module round_sequencer #(
    parameter int unsigned CLOCK_FREQ        = 50_000,
    parameter int unsigned INIT_INTERVAL_SEC = 6,
    parameter int unsigned DESC_INTERVAL_SEC = 2,
    parameter int unsigned MIN_INTERVAL_SEC  = 1,
    parameter int unsigned NEXT_DELAY_CYCLES = 5000,
    parameter int unsigned PTS_MULT          = 1,
    parameter int unsigned MAX_MISSES        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_game,
    output logic        sel_req,
    input  logic        sel_valid,
    input  logic [3:0]  sel_number,
    input  logic        user_valid,
    input  logic [3:0]  user_number,
    output logic [3:0]  target_number,
    output logic        target_valid,
    output logic [31:0] pts_counter,
    output logic [3:0]  miss_count,
    output logic [31:0] interval_cycles,
    output logic        game_over
);

    localparam logic [31:0] INIT_CYC  = 32'(INIT_INTERVAL_SEC * CLOCK_FREQ);
    localparam logic [31:0] DESC_CYC  = 32'(DESC_INTERVAL_SEC * CLOCK_FREQ);
    localparam logic [31:0] MIN_CYC   = 32'(MIN_INTERVAL_SEC * CLOCK_FREQ);
    localparam logic [31:0] DELAY_CYC = 32'(NEXT_DELAY_CYCLES);
    localparam logic [31:0] PTS_INC   = 32'(PTS_MULT);
    localparam logic [3:0]  MAX_MISS  = 4'(MAX_MISSES);
    // Threshold kept 33 bits wide so DESC+MIN cannot wrap.
    localparam logic [32:0] SHRINK_OK = {1'b0, DESC_CYC} + {1'b0, MIN_CYC};

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_SEL, S_ACTIVE, S_HIT, S_MISS, S_DELAY, S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  target_q, target_d;
    logic [31:0] pts_q, pts_d;
    logic [3:0]  miss_q, miss_d;
    logic [31:0] interval_q, interval_d;
    logic [31:0] count_q, count_d;
    logic [31:0] delay_q, delay_d;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        pts_d      = pts_q;
        miss_d     = miss_q;
        interval_d = interval_q;
        count_d    = count_q;
        delay_d    = delay_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_game) begin
                    pts_d      = '0;
                    miss_d     = '0;
                    interval_d = INIT_CYC;
                    state_d    = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT_SEL;
            S_WAIT_SEL: begin
                if (sel_valid) begin
                    target_d = sel_number;
                    count_d  = interval_q;
                    state_d  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (user_valid && (user_number == target_q)) begin
                    state_d = S_HIT;
                end else if (user_valid || (count_q == 32'd1)) begin
                    state_d = S_MISS;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_HIT: begin
                pts_d      = pts_q + PTS_INC;
                interval_d = ({1'b0, interval_q} >= SHRINK_OK) ? (interval_q - DESC_CYC) : MIN_CYC;
                delay_d    = DELAY_CYC;
                state_d    = S_DELAY;
            end
            S_MISS: begin
                miss_d = miss_q + 4'd1;
                if (miss_d == MAX_MISS) begin
                    state_d = S_OVER;
                end else begin
                    delay_d = DELAY_CYC;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (delay_q <= 32'd1) begin
                    state_d = S_REQ;
                end else begin
                    delay_d = delay_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            pts_q      <= '0;
            miss_q     <= '0;
            interval_q <= INIT_CYC;
            count_q    <= '0;
            delay_q    <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            pts_q      <= pts_d;
            miss_q     <= miss_d;
            interval_q <= interval_d;
            count_q    <= count_d;
            delay_q    <= delay_d;
        end
    end

    assign sel_req         = (state_q == S_REQ);
    assign target_valid    = (state_q == S_ACTIVE);
    assign game_over       = (state_q == S_OVER);
    assign target_number   = target_q;
    assign pts_counter     = pts_q;
    assign miss_count      = miss_q;
    assign interval_cycles = interval_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with CLOCK_FREQ=10 (windows 60/-20/floor 10), 3-cycle delay, 3 misses.
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_game;
    logic        sel_req;
    logic        sel_valid;
    logic [3:0]  sel_number;
    logic        user_valid;
    logic [3:0]  user_number;
    logic [3:0]  target_number;
    logic        target_valid;
    logic [31:0] pts_counter;
    logic [3:0]  miss_count;
    logic [31:0] interval_cycles;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    round_sequencer #(
        .CLOCK_FREQ(10),
        .NEXT_DELAY_CYCLES(3),
        .MAX_MISSES(3)
    ) dut (
        .clk(clk), .rst(rst), .start_game(start_game),
        .sel_req(sel_req), .sel_valid(sel_valid), .sel_number(sel_number),
        .user_valid(user_valid), .user_number(user_number),
        .target_number(target_number), .target_valid(target_valid),
        .pts_counter(pts_counter), .miss_count(miss_count),
        .interval_cycles(interval_cycles), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel_req"}, 32'(sel_req), 0);
        chk({tag, "_target"}, 32'(target_number), 0);
        chk({tag, "_tvalid"}, 32'(target_valid), 0);
        chk({tag, "_pts"}, pts_counter, 0);
        chk({tag, "_miss"}, 32'(miss_count), 0);
        chk({tag, "_interval"}, interval_cycles, 60);
        chk({tag, "_over"}, 32'(game_over), 0);
    endtask

    // From the REQ cycle: answer two cycles later, land on ACTIVE cycle 1.
    task automatic give_sel(input logic [3:0] num, input bit noise);
        if (noise) begin
            user_valid  = 1'b1;
            user_number = num;
        end
        step();
        chk("req_one_cycle", 32'(sel_req), 0);
        step();
        sel_valid  = 1'b1;
        sel_number = num;
        step();
        sel_valid  = 1'b0;
        user_valid = 1'b0;
        chk("active_tvalid", 32'(target_valid), 1);
        chk("active_target", 32'(target_number), 32'(num));
    endtask

    task automatic press_at(input logic [3:0] num, input int k);
        repeat (k - 1) step();
        chk("tvalid_before_press", 32'(target_valid), 1);
        user_valid  = 1'b1;
        user_number = num;
        step();
        user_valid = 1'b0;
    endtask

    task automatic wait_req(input bit noise, input logic [3:0] num, output int n);
        bit found   = 0;
        bit tv_seen = 0;
        n = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (noise) begin
                user_valid  = 1'b1;
                user_number = num;
            end
            step();
            n++;
            if (target_valid) tv_seen = 1;
            if (sel_req) found = 1;
        end
        user_valid = 1'b0;
        chk("req_seen", 32'(found), 1);
        chk("tvalid_low_between", 32'(tv_seen), 0);
    endtask

    task automatic active_len(output int n);
        bit done = 0;
        n = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (target_valid) n++;
            else done = 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int reqs;
        logic [31:0] exp_iv [3];
        exp_iv[0] = 32'd20; exp_iv[1] = 32'd10; exp_iv[2] = 32'd10;
        rst = 1'b1; start_game = 1'b0; sel_valid = 1'b0; sel_number = '0;
        user_valid = 1'b0; user_number = '0;
        step(); step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // First round: start latency, target publish, hit on ACTIVE cycle 10.
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        chk("start_latency", 32'(sel_req), 1);
        give_sel(4'd5, 0);
        chk("first_interval", interval_cycles, 60);
        press_at(4'd5, 10);
        chk("hit_tvalid_low", 32'(target_valid), 0);
        wait_req(0, 4'd0, n);
        chk("hit_plus_delay_len", 32'(n), 4);
        chk("pts_after_hit1", pts_counter, 1);
        chk("interval_after_hit1", interval_cycles, 40);

        // Shrinking window saturates at the floor.
        for (int i = 0; i < 3; i++) begin
            give_sel(4'd7, 0);
            press_at(4'd7, 1);
            wait_req(0, 4'd0, n);
            chk("interval_shrink", interval_cycles, exp_iv[i]);
            chk("pts_shrink", pts_counter, 32'(i + 2));
        end

        // Correct press on the last window cycle, then presses outside ACTIVE.
        give_sel(4'd9, 0);
        press_at(4'd9, 10);
        chk("last_cycle_tvalid_low", 32'(target_valid), 0);
        wait_req(1, 4'd9, n);
        chk("last_cycle_hit_pts", pts_counter, 5);
        chk("last_cycle_hit_miss", 32'(miss_count), 0);
        chk("last_cycle_interval", interval_cycles, 10);
        give_sel(4'd5, 1);
        chk("ignored_press_pts", pts_counter, 5);
        chk("ignored_press_miss", 32'(miss_count), 0);

        // Timeout, wrong number, timeout -> game over.
        active_len(n);
        chk("timeout_len_10", 32'(n), 10);
        step();
        chk("miss1", 32'(miss_count), 1);
        wait_req(0, 4'd0, n);
        give_sel(4'd5, 0);
        press_at(4'd3, 1);
        step();
        chk("miss2", 32'(miss_count), 2);
        chk("miss2_interval", interval_cycles, 10);
        chk("miss2_pts", pts_counter, 5);
        wait_req(0, 4'd0, n);
        give_sel(4'd5, 0);
        active_len(n);
        chk("timeout_len_final", 32'(n), 10);
        step();
        chk("over_flag", 32'(game_over), 1);
        chk("over_miss", 32'(miss_count), 3);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            user_valid = 1'b1; user_number = 4'd5;
            sel_valid  = 1'b1; sel_number  = 4'd2;
            step();
            if (sel_req) reqs++;
        end
        user_valid = 1'b0; sel_valid = 1'b0;
        chk("over_no_req", 32'(reqs), 0);
        chk("over_pts_frozen", pts_counter, 5);
        chk("over_miss_frozen", 32'(miss_count), 3);
        chk("over_target_held", 32'(target_number), 5);
        chk("over_still", 32'(game_over), 1);

        // Restart from OVER: full-length window again.
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        chk("restart_req", 32'(sel_req), 1);
        chk("restart_pts", pts_counter, 0);
        chk("restart_miss", 32'(miss_count), 0);
        chk("restart_interval", interval_cycles, 60);
        chk("restart_over", 32'(game_over), 0);
        give_sel(4'd5, 0);
        active_len(n);
        chk("timeout_len_60", 32'(n), 60);
        step();
        chk("restart_miss1", 32'(miss_count), 1);
        wait_req(0, 4'd0, n);

        // Reset in the middle of a round.
        give_sel(4'd6, 0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midreset");
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sel_req) reqs++;
        end
        chk("idle_holds", 32'(reqs), 0);
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        chk("idle_start_req", 32'(sel_req), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
